kbd_rx_fifo: RTL and testbench
==============================

KBD_RX_FIFO -- requirements
Module: kbd_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT, default 5000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 io_rdn  input  1  active-low I/O read strobe from the address decoder.
REQ-008 key_data  output  8  scan code at FIFO head; 8'h00 when empty.
REQ-009 ready  output  1  high while FIFO holds at least one byte.
REQ-010 overflow  output  1  sticky: a received byte was dropped because the FIFO was full.
REQ-011 parity_err  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-012 ps2_clk and ps2_data each pass through a 3-flop synchronizer; a falling edge is flop2=0 and flop3=1.
REQ-013 ps2_data is sampled from its synchronized value in the cycle the falling edge is detected.
REQ-014 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on falling edge with data=0 (start bit) -> DATA, bit count 0; data=1 stays IDLE.
REQ-016 DATA: each falling edge shifts one bit in, LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: falling edge captures the parity bit -> STOP.
REQ-018 STOP: on falling edge -> IDLE; frame valid iff stop bit=1 and XOR of 8 data bits and parity bit = 1 (odd parity).
REQ-019 Valid frame: byte pushed into FIFO in the cycle after the stop-bit edge.
REQ-020 Invalid frame (bad parity or stop=0): byte discarded, parity_err high for exactly one cycle.
REQ-021 Idle timer counts clk cycles in DATA/PARITY/STOP, clears on every falling edge; at TIMEOUT the FSM returns to IDLE, partial byte discarded, no parity_err.
REQ-022 Pop occurs in a cycle where io_rdn=0 and the registered previous io_rdn=1; one pop per read access regardless of strobe length.
REQ-023 key_data and ready are combinational from FIFO head/count so a read returns the head in the strobe cycle; the pop takes effect at the following edge.
REQ-024 Pop when empty: no effect, pointers unchanged.
REQ-025 Push when full: byte dropped, overflow set; FIFO contents unchanged.
REQ-026 Push and pop in the same cycle: both performed, count unchanged; when full, simultaneous pop makes room and the push is accepted, overflow not set.
REQ-027 overflow clears on the next accepted pop.
REQ-028 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.

Reset
REQ-029 clrn=0 forces immediately: FSM IDLE, bit count 0, idle timer 0, pointers 0, count 0, synchronizer flops 1, io_rdn history 1.
REQ-030 During and after reset: ready=0, key_data=8'h00, overflow=0, parity_err=0.
REQ-031 Reset mid-frame discards the partial byte; the first frame after clrn rises must begin with a fresh start bit.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1 -> ready=1, key_data=8'h1C in the cycle after the stop-bit edge; one io_rdn low pulse -> ready=0, key_data=8'h00.
REQ-033 Frame 0x1C with parity 1 -> parity_err pulses one cycle, ready stays 0.
REQ-034 DEPTH=8: send 9 frames 0x01..0x09, no reads -> overflow=1; 8 reads return 0x01..0x08 in order; overflow clears after first read.
REQ-035 4 data bits sent then ps2_clk held high TIMEOUT cycles, then full frame 0x5A -> only 0x5A in FIFO.
REQ-036 FIFO full; io_rdn falling edge coincides with push cycle of 0x77 -> count stays 8, overflow=0, 0x77 is last byte read.
REQ-037 clrn pulsed low after 5 bits of a frame, then full frame 0x29 -> FIFO holds only 0x29; io_rdn held low 10 cycles pops exactly one byte.

Source files
------------

// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo -- PS/2 keyboard receiver feeding a small scan-code FIFO.
//
// Frames from the keyboard (start, 8 data LSB first, odd parity, stop) are
// sampled on ps2_clk falling edges after synchronisation into clk. Good
// frames are queued; the CPU reads the head through an active-low read
// strobe, one entry per strobe regardless of how long it stays low.
//
// Ports
//   clk        system clock, rising edge
//   clrn       asynchronous active-low reset
//   ps2_clk    PS/2 device clock (async)
//   ps2_data   PS/2 device data (async)
//   io_rdn     active-low read strobe from the address decoder
//   key_data   byte at FIFO head, 8'h00 when empty (combinational)
//   ready      FIFO non-empty (combinational)
//   overflow   sticky: a byte was dropped because the FIFO was full
//   parity_err one-cycle pulse when a frame is rejected
module kbd_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rdn,
  output logic [7:0] key_data,
  output logic       ready,
  output logic       overflow,
  output logic       parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // ---------------------------------------------------------------------
  // Synchronisers: bit0 = first flop, bit2 = third flop. Reset to 1 so a
  // bus idling high never looks like a falling edge coming out of reset.
  // ---------------------------------------------------------------------
  logic [2:0] clk_sync, dat_sync;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  logic fall, din;
  assign fall = !clk_sync[1] && clk_sync[2];
  // Data taken from the same synchroniser depth as the clock edge detect.
  assign din  = dat_sync[1];

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          push_req;
  logic [7:0]    push_byte;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      timer      <= '0;
      push_req   <= 1'b0;
      push_byte  <= '0;
      parity_err <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      parity_err <= 1'b0;
      if (fall) begin
        timer <= '0;
        unique case (state)
          IDLE: begin
            if (!din) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= din;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // Odd parity over data + parity bit, and a high stop bit.
            if (din && ((^shreg) ^ par_bit)) begin
              push_req  <= 1'b1;
              push_byte <= shreg;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Abandon a stalled partial frame silently.
        if (timer == TMAX) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read strobe edge detect: one pop per strobe falling edge.
  // ---------------------------------------------------------------------
  logic rdn_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) rdn_q <= 1'b1;
    else       rdn_q <= io_rdn;
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = !io_rdn && rdn_q && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (pop)                 overflow <= 1'b0;
    end
  end

  assign ready    = !empty;
  assign key_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// Directed bench for kbd_rx_fifo: a vector table of single frames plus
// hand-timed sequences for overflow, timeout, push/pop collision and reset.
module tb_kbd_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 100;
  localparam int HALF    = 10;   // clk cycles per PS/2 half period

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       io_rdn = 1'b1;
  logic [7:0] key_data;
  logic       ready, overflow, parity_err;

  kbd_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .io_rdn(io_rdn), .key_data(key_data), .ready(ready),
    .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int perr_cnt = 0;

  always @(posedge clk) if (parity_err) perr_cnt <= perr_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Start, data, parity (odd, optionally inverted) up to but excluding stop.
  task automatic send_head(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    send_head(d, bad_par);
    send_bit(stop);
    repeat (5) @(negedge clk);
  endtask

  task automatic read_byte(output logic [7:0] v);
    @(negedge clk);
    io_rdn = 1'b0;
    #1 v = key_data;
    @(negedge clk);
    io_rdn = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       bad_par;
    logic       stop;
    logic       exp_ready;
    logic [7:0] exp_key;
    int         exp_perr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] v;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 0};

    // Reset state, checked while reset is asserted and after release.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_key", {24'b0, key_data}, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", {31'b0, ready}, 0);
    chk("post_rst_key", {24'b0, key_data}, 0);
    chk("post_rst_ovf", {31'b0, overflow}, 0);
    chk("post_rst_perr", {31'b0, parity_err}, 0);

    // Exact push latency: stop edge detected two clocks after ps2_clk drops,
    // byte visible one clock after that.
    send_head(8'h1C, 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_ready_early", {31'b0, ready}, 0);
    @(negedge clk);
    chk("lat_ready", {31'b0, ready}, 1);
    chk("lat_key", {24'b0, key_data}, 32'h1C);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    read_byte(v);
    chk("lat_read", {24'b0, v}, 32'h1C);
    chk("lat_empty", {31'b0, ready}, 0);
    chk("lat_empty_key", {24'b0, key_data}, 0);

    // Vector table: one frame each, then drain.
    foreach (vecs[i]) begin
      perr_cnt = 0;
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop);
      chk($sformatf("vec%0d_ready", i), {31'b0, ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_key", i), {24'b0, key_data}, {24'b0, vecs[i].exp_key});
      chk($sformatf("vec%0d_perr", i), perr_cnt, vecs[i].exp_perr);
      if (vecs[i].exp_ready) begin
        read_byte(v);
        chk($sformatf("vec%0d_drain", i), {31'b0, ready}, 0);
      end
    end

    // Overflow: nine frames into eight slots.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    chk("ovf_set", {31'b0, overflow}, 1);
    for (int i = 1; i <= 8; i++) begin
      read_byte(v);
      chk($sformatf("ovf_read%0d", i), {24'b0, v}, i);
      if (i == 1) chk("ovf_clear", {31'b0, overflow}, 0);
    end
    chk("ovf_empty", {31'b0, ready}, 0);

    // Timeout: partial frame abandoned, then a clean frame.
    perr_cnt = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TIMEOUT + 20) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("to_perr", perr_cnt, 0);
    read_byte(v);
    chk("to_key", {24'b0, v}, 32'h5A);
    chk("to_empty", {31'b0, ready}, 0);

    // Full FIFO: strobe falls exactly in the push cycle of 0x77.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
    send_head(8'h77, 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    io_rdn = 1'b0;
    #1 v = key_data;
    @(negedge clk);
    io_rdn = 1'b1;
    chk("col_head", {24'b0, v}, 32'h10);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("col_ovf", {31'b0, overflow}, 0);
    for (int i = 1; i <= 8; i++) begin
      read_byte(v);
      chk($sformatf("col_read%0d", i), {24'b0, v}, (i == 8) ? 32'h77 : 32'h10 + i);
    end
    chk("col_empty", {31'b0, ready}, 0);

    // Reset mid-frame, then a fresh frame; a long strobe pops once.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_ready", {31'b0, ready}, 0);
    clrn = 1'b1;
    send_frame(8'h29, 1'b0, 1'b1);
    chk("mr_key", {24'b0, key_data}, 32'h29);
    @(negedge clk);
    io_rdn = 1'b0;
    repeat (10) @(negedge clk);
    io_rdn = 1'b1;
    @(negedge clk);
    chk("mr_empty", {31'b0, ready}, 0);
    send_frame(8'h33, 1'b0, 1'b1);
    send_frame(8'h44, 1'b0, 1'b1);
    @(negedge clk);
    io_rdn = 1'b0;
    repeat (10) @(negedge clk);
    io_rdn = 1'b1;
    @(negedge clk);
    chk("long_rd_ready", {31'b0, ready}, 1);
    chk("long_rd_key", {24'b0, key_data}, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
